packet_queue: RTL and testbench

- Synchronous FIFO for complete packets between packet_loader's SEND_PC_TO_QU port and the execution-side consumer.
- Absorbs bursts of OPCODE_EI packets so the loader never stalls on a slow executor.
- Uses the same VALID/DATA/READY handshake as every other stage: a transfer happens on a rising CLK edge when VALID and READY are both 1.

---
 rtl/packet_queue_pkg.sv | 12 +
 rtl/packet_queue_if.sv | 33 +++
 rtl/packet_queue_ram.sv | 35 +++
 rtl/packet_queue.sv | 116 +++++++++++
 tb/tb_packet_queue.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/packet_queue_pkg.sv
// packet_queue_pkg
// Purpose : shared constants for the packet queue slice.
//   PQ_PACKET_WIDTH : default packet width (5x32 + 15 bits), matches the shared packet format.
//   PQ_DEPTH        : default queue depth in packets (power of two, >= 2).
//   PQ_STALL_WIDTH  : width of the optional saturating stall counter.
package packet_queue_pkg;

    localparam int unsigned PQ_PACKET_WIDTH = 175;
    localparam int unsigned PQ_DEPTH        = 8;
    localparam int unsigned PQ_STALL_WIDTH  = 16;

endpackage

// File: rtl/packet_queue_if.sv
// packet_queue_if
// Purpose : VALID/DATA/READY packet handshake. A transfer happens on a rising clock edge
//           when valid and ready are both 1.
// Signals :
//   valid : producer has a packet
//   data  : packet contents (WIDTH bits)
//   ready : consumer can take the packet
// Modports:
//   master : producer side (drives valid/data, observes ready)
//   slave  : consumer side (observes valid/data, drives ready)
interface packet_queue_if
    import packet_queue_pkg::*;
#(
    parameter int unsigned WIDTH = PQ_PACKET_WIDTH
);

    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/packet_queue_ram.sv
// packet_queue_ram
// Purpose : DEPTH x WIDTH storage with one synchronous write port and one asynchronous
//           read port. Kept separate so it can be swapped for a vendor RAM later.
// Ports   :
//   i_clk   : clock, write on rising edge
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : write data
//   i_raddr : read index
//   o_rdata : combinational read data
// Storage is never cleared; contents after reset are don't-care.
module packet_queue_ram #(
    parameter int unsigned WIDTH      = 175,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/packet_queue.sv
// packet_queue
// Purpose : first-word-fall-through FIFO of complete packets between the packet loader
//           and the execution-side consumer; absorbs bursts so the loader does not stall.
// Ports   :
//   CLK         : clock, rising edge
//   RST         : asynchronous active-high reset
//   RECEIVE_PC  : upstream handshake (slave), ready is a registered flag
//   SEND_PC     : downstream handshake (master), head packet falls through
//   COUNT       : occupancy 0..DEPTH
//   HIGH_WATER  : max COUNT since reset           (only with PACKET_QUEUE_STATS_EN)
//   STALL_COUNT : saturating blocked-valid cycles (only with PACKET_QUEUE_STATS_EN)
// Optional feature macro: PACKET_QUEUE_STATS_EN
module packet_queue
    import packet_queue_pkg::*;
#(
    parameter  int unsigned PACKET_WIDTH = PQ_PACKET_WIDTH,
    parameter  int unsigned DEPTH        = PQ_DEPTH,
    localparam int unsigned PTR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    packet_queue_if.slave        RECEIVE_PC,
    packet_queue_if.master       SEND_PC,
`ifdef PACKET_QUEUE_STATS_EN
    output logic [PTR_WIDTH:0]   HIGH_WATER,
    output logic [15:0]          STALL_COUNT,
`endif
    output logic [PTR_WIDTH:0]   COUNT
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_WIDTH:0] r_wr_ptr;
    logic [PTR_WIDTH:0] r_rd_ptr;
    logic               r_valid;
    logic               r_ready;

    logic               w_push;
    logic               w_pop;
    logic [PTR_WIDTH:0] w_wr_ptr_nxt;
    logic [PTR_WIDTH:0] w_rd_ptr_nxt;
    logic               w_empty_nxt;
    logic               w_full_nxt;
    logic [PTR_WIDTH:0] w_count_nxt;

    assign w_push = RECEIVE_PC.valid & r_ready;
    assign w_pop  = r_valid & SEND_PC.ready;

    assign w_wr_ptr_nxt = r_wr_ptr + {{PTR_WIDTH{1'b0}}, w_push};
    assign w_rd_ptr_nxt = r_rd_ptr + {{PTR_WIDTH{1'b0}}, w_pop};
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    assign w_full_nxt  = (w_wr_ptr_nxt[PTR_WIDTH-1:0] == w_rd_ptr_nxt[PTR_WIDTH-1:0]) &&
                         (w_wr_ptr_nxt[PTR_WIDTH] != w_rd_ptr_nxt[PTR_WIDTH]);

    // Valid and ready are both registered from the next-state pointers: no combinational
    // path from SEND_PC.ready to RECEIVE_PC.ready, so a pop while full only frees the slot
    // for the following cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_valid  <= !w_empty_nxt;
            r_ready  <= !w_full_nxt;
        end
    end

    logic [PACKET_WIDTH-1:0] w_rdata;

    packet_queue_ram #(
        .WIDTH      (PACKET_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_ram (
        .i_clk   (CLK),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[PTR_WIDTH-1:0]),
        .i_wdata (RECEIVE_PC.data),
        .i_raddr (r_rd_ptr[PTR_WIDTH-1:0]),
        .o_rdata (w_rdata)
    );

    assign RECEIVE_PC.ready = r_ready;
    assign SEND_PC.valid    = r_valid;
    assign SEND_PC.data     = w_rdata;
    assign COUNT            = r_wr_ptr - r_rd_ptr;

`ifdef PACKET_QUEUE_STATS_EN
    logic [PTR_WIDTH:0]      r_high_water;
    logic [PQ_STALL_WIDTH-1:0] r_stall_count;

    // Tracking the next count keeps HIGH_WATER in step with COUNT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_high_water  <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_count_nxt > r_high_water) begin
                r_high_water <= w_count_nxt;
            end
            if (RECEIVE_PC.valid && !r_ready && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign HIGH_WATER  = r_high_water;
    assign STALL_COUNT = r_stall_count;
`endif

endmodule

// File: tb/tb_packet_queue.sv
// tb_packet_queue
// Purpose : self-checking bench for packet_queue. A queue-based model tracks what the
//           FIFO must hold; a compare process checks outputs every falling edge, and a few
//           literal checks pin the directed scenarios.
module tb_packet_queue;
    import packet_queue_pkg::*;

    localparam int unsigned PW    = PQ_PACKET_WIDTH;
    localparam int unsigned DEPTH = PQ_DEPTH;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] count;
`ifdef PACKET_QUEUE_STATS_EN
    logic [CW-1:0] high_water;
    logic [15:0]   stall_count;
`endif

    packet_queue_if #(.WIDTH(PW)) rx_if ();
    packet_queue_if #(.WIDTH(PW)) tx_if ();

    packet_queue #(
        .PACKET_WIDTH (PW),
        .DEPTH        (DEPTH)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .RECEIVE_PC  (rx_if.slave),
        .SEND_PC     (tx_if.master),
`ifdef PACKET_QUEUE_STATS_EN
        .HIGH_WATER  (high_water),
        .STALL_COUNT (stall_count),
`endif
        .COUNT       (count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: contents as a queue, ready as "not full after this edge".
    logic [PW-1:0] mq[$];
    bit            m_ready = 1'b0;
    int            m_hw    = 0;
    int            m_stall = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ready = 1'b0;
            m_hw    = 0;
            m_stall = 0;
        end else begin
            bit do_push;
            bit do_pop;
            do_push = (rx_if.valid === 1'b1) && m_ready;
            do_pop  = (mq.size() != 0) && (tx_if.ready === 1'b1);
            if (rx_if.valid === 1'b1 && !m_ready && m_stall < 16'hFFFF) m_stall++;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(rx_if.data);
            m_ready = (mq.size() != DEPTH);
            if (mq.size() > m_hw) m_hw = mq.size();
        end
    end

    always @(negedge clk) begin
        check("ready", {191'd0, rx_if.ready}, {191'd0, m_ready});
        check("valid", {191'd0, tx_if.valid}, {191'd0, mq.size() != 0});
        check("count", {{(192-CW){1'b0}}, count}, 192'(mq.size()));
        if (mq.size() != 0) check("data", {{(192-PW){1'b0}}, tx_if.data}, {{(192-PW){1'b0}}, mq[0]});
`ifdef PACKET_QUEUE_STATS_EN
        check("high_water", {{(192-CW){1'b0}}, high_water}, 192'(m_hw));
        check("stall_count", {176'd0, stall_count}, 192'(m_stall));
`endif
    end

    function automatic logic [PW-1:0] rand_pkt();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[PW-1:0];
    endfunction

    // Called just after a rising edge: apply inputs, then advance to just after the next one.
    task automatic drive(input bit v, input logic [PW-1:0] d, input bit r);
        rx_if.valid = v;
        rx_if.data  = d;
        tx_if.ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    logic [PW-1:0] pkt;
    int            acc;
    int            cyc;

    initial begin
        rx_if.valid = 1'b0;
        rx_if.data  = '0;
        tx_if.ready = 1'b0;
        rst = 1'b1;

        // Reset for one cycle.
        @(posedge clk);
        #1;
        check("rst_ready", {191'd0, rx_if.ready}, 192'd0);
        check("rst_valid", {191'd0, tx_if.valid}, 192'd0);
        check("rst_count", {{(192-CW){1'b0}}, count}, 192'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", {191'd0, rx_if.ready}, 192'd1);

        // Single packet in, then out.
        pkt = rand_pkt();
        drive(1'b1, pkt, 1'b0);
        check("single_valid", {191'd0, tx_if.valid}, 192'd1);
        check("single_data", {{(192-PW){1'b0}}, tx_if.data}, {{(192-PW){1'b0}}, pkt});
        check("single_count", {{(192-CW){1'b0}}, count}, 192'd1);
        drive(1'b0, '0, 1'b1);
        check("single_pop_valid", {191'd0, tx_if.valid}, 192'd0);
        check("single_pop_count", {{(192-CW){1'b0}}, count}, 192'd0);

        // Fill to DEPTH with the consumer stalled.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, rand_pkt(), 1'b0);
        check("fill_count", {{(192-CW){1'b0}}, count}, 192'(DEPTH));
        check("fill_ready", {191'd0, rx_if.ready}, 192'd0);
        pkt = rand_pkt();
        for (int i = 0; i < 3; i++) drive(1'b1, pkt, 1'b0);
        check("overfill_count", {{(192-CW){1'b0}}, count}, 192'(DEPTH));

        // Pop while full: no push that cycle, ready returns one cycle later.
        drive(1'b1, pkt, 1'b1);
        check("fullpop_count", {{(192-CW){1'b0}}, count}, 192'(DEPTH - 1));
        check("fullpop_ready", {191'd0, rx_if.ready}, 192'd1);
        drive(1'b1, pkt, 1'b0);
        check("refill_count", {{(192-CW){1'b0}}, count}, 192'(DEPTH));
`ifdef PACKET_QUEUE_STATS_EN
        check("stats_high_water", {{(192-CW){1'b0}}, high_water}, 192'(DEPTH));
        check("stats_stall", {176'd0, stall_count}, 192'd4);
`endif
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1);
        check("drain_count", {{(192-CW){1'b0}}, count}, 192'd0);

        // Random streaming of 40 packets; the model checks order every cycle.
        acc = 0;
        cyc = 0;
        while (acc < 40 && cyc < 2000) begin
            bit v;
            v = $urandom_range(0, 1) == 1;
            if (v && m_ready) acc++;
            drive(v, rand_pkt(), $urandom_range(0, 2) != 0);
            cyc++;
        end
        check("stream_accepted", 192'(acc), 192'd40);
        cyc = 0;
        while (mq.size() != 0 && cyc < 50) begin
            drive(1'b0, '0, 1'b1);
            cyc++;
        end
        check("stream_drained", {{(192-CW){1'b0}}, count}, 192'd0);

        // Mid-operation reset with five packets queued.
        for (int i = 0; i < 5; i++) drive(1'b1, rand_pkt(), 1'b0);
        check("pre_rst_count", {{(192-CW){1'b0}}, count}, 192'd5);
        drive(1'b0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {191'd0, tx_if.valid}, 192'd0);
        check("async_rst_count", {{(192-CW){1'b0}}, count}, 192'd0);
        check("async_rst_ready", {191'd0, rx_if.ready}, 192'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, '0, 1'b1);
        check("post_rst_ready", {191'd0, rx_if.ready}, 192'd1);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);
        check("post_rst_valid", {191'd0, tx_if.valid}, 192'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
